// File: rtl/calc3_shift_pkg.sv
// Shared definitions for the shifter execution stage: widths, command/response codes, pipeline payloads.
package calc3_shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned FB_W    = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CMD_W-1:0] CMD_IDLE  = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SHL   = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_SHR   = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_STORE = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_FETCH = 4'b1010;

    localparam logic [RESP_W-1:0] RESP_OK  = 2'b01;
    localparam logic [RESP_W-1:0] RESP_ERR = 2'b10;

    // Operands captured in E1
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic              wb_en;
        logic [REG_W-1:0]  wb_adr;
        logic [FB_W-1:0]   fb;
        logic              v1;
        logic              v2;
        logic              sdv;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } e1_entry_t;

    // Response held in E2
    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [FB_W-1:0]   fb;
        logic              wb;
        logic [REG_W-1:0]  wb_adr;
    } e2_entry_t;

endpackage

// File: rtl/shift_barrel32.sv
// Combinational 32-bit logical shifter; zero fill in both directions.
module shift_barrel32
    import calc3_shift_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               dir_right,
    output logic [DATA_W-1:0]  result
);

    always_comb begin
        result = dir_right ? (data >> amount) : (data << amount);
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shifter execution: E1 captures the issued command, E2 computes and holds the
// tagged response until downstream accepts it, strobing the register writeback on acceptance.
module shift_exec_stage
    import calc3_shift_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  shift_out_cmd,
    input  logic [0:3]  shift_tag,
    input  logic [0:4]  shift_result_reg,
    input  logic [0:4]  shift_follow_branch,
    input  logic        shift_read_valid1,
    input  logic        shift_read_valid2,
    input  logic [0:31] shift_read_data1,
    input  logic [0:31] shift_read_data2,
    input  logic [0:63] store_val,
    input  logic        store_data_valid,
    input  logic        shift_out_rdy,
    output logic        shift_busy,
    output logic        shift_out_vld,
    output logic [0:1]  shift_out_resp,
    output logic [0:31] shift_out_data,
    output logic [0:3]  shift_out_tag,
    output logic [0:4]  shift_out_follow_branch,
    output logic        shift_wr_en,
    output logic [0:3]  shift_wr_adr,
    output logic [0:31] shift_wr_data,
    output logic        shift_drop_err
);

    e1_entry_t         in_entry, e1_q;
    e2_entry_t         e2_d, e2_q;
    logic              e1_vld, e2_vld;
    logic              accept, advance, drain, cmd_present;
    logic [DATA_W-1:0] shifted;
    logic              ok;
    logic [DATA_W-1:0] res;
    logic              unused_store_hi;

    // Upper store word carries nothing for this stage
    assign unused_store_hi = ^store_val[0:31];

    assign cmd_present = (CMD_W'(shift_out_cmd) != CMD_IDLE);
    assign shift_busy  = e1_vld & e2_vld & ~shift_out_rdy;
    assign drain       = e2_vld & shift_out_rdy;
    assign advance     = e1_vld & (~e2_vld | shift_out_rdy);
    assign accept      = cmd_present & ~shift_busy;

    // Store commands take their second operand from the low store word
    always_comb begin
        in_entry        = '0;
        in_entry.cmd    = shift_out_cmd;
        in_entry.tag    = shift_tag;
        in_entry.wb_en  = shift_result_reg[0];
        in_entry.wb_adr = shift_result_reg[1:4];
        in_entry.fb     = shift_follow_branch;
        in_entry.v1     = shift_read_valid1;
        in_entry.v2     = shift_read_valid2;
        in_entry.sdv    = store_data_valid;
        in_entry.d1     = shift_read_data1;
        in_entry.d2     = (CMD_W'(shift_out_cmd) == CMD_STORE) ? store_val[32:63] : shift_read_data2;
    end

    shift_barrel32 u_barrel (
        .data      (e1_q.d1),
        .amount    (e1_q.d2[SHAMT_W-1:0]),
        .dir_right (e1_q.cmd == CMD_SHR),
        .result    (shifted)
    );

    // E2 result; any failed operand check forces data to zero and suppresses writeback
    always_comb begin
        ok   = 1'b0;
        res  = '0;
        e2_d = '0;
        case (e1_q.cmd)
            CMD_SHL, CMD_SHR: begin
                ok  = e1_q.v1 & e1_q.v2;
                res = shifted;
            end
            CMD_STORE: begin
                ok  = e1_q.sdv;
                res = e1_q.d2;
            end
            CMD_FETCH: begin
                ok  = e1_q.v1;
                res = e1_q.d1;
            end
            default: ;
        endcase
        e2_d.resp   = ok ? RESP_OK : RESP_ERR;
        e2_d.data   = ok ? res : '0;
        e2_d.tag    = e1_q.tag;
        e2_d.fb     = e1_q.fb;
        e2_d.wb     = ok & (e1_q.cmd != CMD_FETCH) & e1_q.wb_en;
        e2_d.wb_adr = e1_q.wb_adr;
    end

    always_ff @(negedge c_clk or negedge reset) begin
        if (!reset) begin
            e1_vld <= 1'b0;
            e1_q   <= '0;
        end else if (accept) begin
            e1_vld <= 1'b1;
            e1_q   <= in_entry;
        end else if (advance) begin
            e1_vld <= 1'b0;
        end
    end

    // E2 reloads in the same edge it drains, so back-to-back responses see no bubble
    always_ff @(negedge c_clk or negedge reset) begin
        if (!reset) begin
            e2_vld <= 1'b0;
            e2_q   <= '0;
        end else if (advance) begin
            e2_vld <= 1'b1;
            e2_q   <= e2_d;
        end else if (drain) begin
            e2_vld <= 1'b0;
        end
    end

    always_ff @(negedge c_clk or negedge reset) begin
        if (!reset) begin
            shift_drop_err <= 1'b0;
        end else begin
            shift_drop_err <= cmd_present & shift_busy;
        end
    end

    assign shift_out_vld           = e2_vld;
    assign shift_out_resp          = e2_q.resp;
    assign shift_out_data          = e2_q.data;
    assign shift_out_tag           = e2_q.tag;
    assign shift_out_follow_branch = e2_q.fb;
    assign shift_wr_en             = e2_vld & shift_out_rdy & e2_q.wb;
    assign shift_wr_adr            = e2_q.wb_adr;
    assign shift_wr_data           = e2_q.data;

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execution stage directly downstream of the shifter input stage. Consumes its registered command, tag, result register, follow-branch and store data, plus register-file read data for its read addresses.
- Performs shift-left/shift-right/store/fetch and drives a tagged response plus a register writeback.
- Two-stage pipeline: E1 operand capture, E2 compute/output, with a ready/valid output handshake and backpressure to the input stage.

Parameters:
- DATA_W, 32, operand/result width; shift amount is the low 5 bits of operand 2.
- TAG_W, 4, tag width.

Ports:
- c_clk  input  1  stage clock; all flops on negedge c_clk, matching the input stage.
- reset  input  1  asynchronous active-low reset: 0 = reset asserted, acts immediately; released synchronously to the c_clk negedge.
- shift_out_cmd  input  [0:3]  0101 shl, 0110 shr, 1001 store, 1010 fetch, 0000 idle.
- shift_tag  input  [0:3]  request tag.
- shift_result_reg  input  [0:4]  bit0 = writeback enable, [1:4] = destination register.
- shift_follow_branch  input  [0:4]  carried unchanged to the output.
- shift_read_valid1, shift_read_valid2  input  1 each  operand-valid flags.
- shift_read_data1, shift_read_data2  input  [0:31] each  register-file data, same cycle as the command.
- store_val  input  [0:63]  store data; bits [32:63] used.
- store_data_valid  input  1  qualifies store_val.
- shift_out_rdy  input  1  downstream ready.
- shift_busy  output  1  upstream must not issue while 1.
- shift_out_vld  output  1  response valid.
- shift_out_resp  output  [0:1]  01 success, 10 error.
- shift_out_data  output  [0:31]  result.
- shift_out_tag  output  [0:3]  echoed tag.
- shift_out_follow_branch  output  [0:4]  echoed follow-branch value.
- shift_wr_en  output  1  register writeback strobe.
- shift_wr_adr  output  [0:3]  writeback register.
- shift_wr_data  output  [0:31]  writeback data.
- shift_drop_err  output  1  one-cycle pulse when a command arrives while shift_busy = 1.

Behaviour:
- Reset (reset = 0): E1/E2 valid = 0. All outputs 0: shift_out_vld, shift_out_resp = 00, shift_out_data, shift_out_tag, shift_out_follow_branch, shift_wr_en, shift_wr_adr, shift_wr_data, shift_busy, shift_drop_err. Reset mid-operation discards all in-flight entries with no response.
- Accept: command is nonzero out_cmd and shift_busy = 0. E1 captures cmd, tag, result_reg, follow_branch, valid1/2, data1, and data2 (or store_val[32:63] for 1001).
- shift_busy = E1_vld & E2_vld & ~shift_out_rdy (combinational).
- Command arriving with shift_busy = 1: not captured; shift_drop_err = 1 next cycle.
- E2 advance: E1 moves to E2 when E2 is empty or (shift_out_vld & shift_out_rdy). Otherwise E1 holds.
- E2 holds its outputs stable while shift_out_vld = 1 and shift_out_rdy = 0.
- Latency: command to shift_out_vld is 2 cycles with rdy high. Throughput is 1 per cycle.
- Compute in E2 (registered outputs):
  - shl: d1 << d2[27:31], logical; bits shifted out are lost; no overflow error.
  - shr: d1 >> d2[27:31], logical, zero fill.
  - Shift by 0 returns d1 unchanged.
  - store: data = store_val[32:63]; resp 10 if store_data_valid was 0 at capture.
  - fetch: data = d1; no writeback.
- Error: any required operand valid = 0 gives resp 10, data 0, no writeback. shl/shr need valid1 and valid2; fetch needs valid1.
- Writeback: shift_wr_en = 1 for exactly one cycle, on the cycle shift_out_vld & shift_out_rdy, when resp = 01, cmd is not fetch, and result_reg[0] = 1. shift_wr_adr = result_reg[1:4].
- shift_out_vld stays 1 until accepted; there is never more than one writeback per response.
- Simultaneous accept and E2 drain in the same cycle: both occur and no bubble is inserted.

Decomposition:
- Shared package calc3_shift_pkg:
  - Command codes: CMD_SHL 0101, CMD_SHR 0110, CMD_STORE 1001, CMD_FETCH 1010.
  - Response codes: RESP_OK 01, RESP_ERR 10.
  - DATA_W and TAG_W.
- One sub-module, shift_barrel32: combinational 32-bit logical shifter with direction and 5-bit amount inputs.

Test Plan:
- Command shl, d1 = 0000_0001, d2 = 4, result_reg = 1_0011, tag 5, rdy = 1 → 2 cycles later vld = 1, resp 01, data 0000_0010, tag 5. Same cycle: wr_en = 1, wr_adr = 0011.
- Command shr, d1 = 8000_0000, d2 = 31 → data 0000_0001. Then shl with d2 = 0x25 (uses low 5 bits = 5), d1 = FFFF_FFFF → data FFFF_FFE0.
- Command shl with valid2 = 0 → resp 10, data 0, wr_en never asserted.
- Hold rdy = 0 and issue 2 commands → shift_busy = 1. A third command is dropped with a drop_err pulse. E2 outputs stay stable. Raise rdy → 2 responses in order, tags preserved.
- Command store with store_val = 0000_0000_DEAD_BEEF and store_data_valid = 1 → data DEADBEEF, wr_en = 1. Command fetch → data = d1, wr_en = 0.
- Assert reset low with 2 commands in flight → all outputs 0 immediately; no response after release.
